data_io_sync: RTL and testbench

- Next-generation SPI slave between the board microcontroller and the core. It carries menu status, config bytes, the config string, file index and ROM download.
- Unlike the SPI-clocked predecessor, SCK/SS/DI are oversampled and every register lives in clk_sys.
- Adds a parametrised download width (8/16-bit), a write FIFO with ioctl_wait backpressure, chunked downloads and an overflow flag.
- Sits between the top-level SPI pins and the jtframe ROM loader / status consumers.

---
 rtl/data_io_sync.sv | 257 +++++++++++++++++++++++++
 tb/tb_data_io_sync.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_sync.sv
// Oversampled SPI slave: menu status, config bytes, config string and ROM download
// into a small write FIFO drained towards the loader. Everything runs in clk_sys.
module data_io_sync #(
  parameter int          DW           = 8,
  parameter int          AW           = 25,
  parameter int          CFG_BYTES    = 16,
  parameter int          STATUS_BYTES = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  ACK          = 8'h4B
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    spi_sck,
  input  logic                    spi_ss2,
  input  logic                    spi_di,
  output logic                    spi_do,
  output logic                    spi_do_oe,
  input  logic [7:0]              data_in,
  output logic [9:0]              conf_addr,
  input  logic [7:0]              conf_chr,
  output logic [8*STATUS_BYTES-1:0] status,
  output logic [6:0]              core_mod,
  output logic [8*CFG_BYTES-1:0]  config_buffer,
  output logic                    ioctl_download,
  output logic [7:0]              ioctl_index,
  output logic                    ioctl_wr,
  output logic [AW-1:0]           ioctl_addr,
  output logic [DW-1:0]           ioctl_dout,
  input  logic                    ioctl_wait,
  output logic                    ioctl_err
);

  localparam int CW = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam int SW = $clog2(STATUS_BYTES + 2);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int EW = AW + DW;
  localparam logic [FW:0]   FULL = (FW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  logic [2:0] sck_q;
  logic [1:0] ss_q, di_q;
  logic       sck_rise, sck_fall, ss_hi, di_s;

  // Select synchronizer idles high so MISO stays disabled straight out of reset.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sck_q     <= 3'b000;
      ss_q      <= 2'b11;
      di_q      <= 2'b00;
      spi_do_oe <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], spi_sck};
      ss_q      <= {ss_q[0], spi_ss2};
      di_q      <= {di_q[0], spi_di};
      spi_do_oe <= ~ss_q[1];
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_hi    = ss_q[1];
  assign di_s     = di_q[1];

  logic [2:0] bit_cnt;
  logic       have_cmd, cmd_stb, data_stb;
  logic [7:0] cmd, rx_byte, tx_sr, tx_next;
  logic [6:0] rx_sr;

  always_comb begin
    tx_next = 8'h00;
    case (cmd)
      8'h00:   tx_next = ACK;
      8'h10:   tx_next = data_in;
      8'h14:   tx_next = conf_chr;
      default: tx_next = 8'h00;
    endcase
  end

  // The reply byte is loaded on the falling edge that ends the previous byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      have_cmd <= 1'b0;
      cmd      <= 8'h00;
      rx_sr    <= 7'h00;
      rx_byte  <= 8'h00;
      tx_sr    <= 8'h00;
      cmd_stb  <= 1'b0;
      data_stb <= 1'b0;
    end else if (ss_hi) begin
      bit_cnt  <= 3'd0;
      have_cmd <= 1'b0;
      cmd      <= 8'h00;
      rx_sr    <= 7'h00;
      tx_sr    <= ACK;
      cmd_stb  <= 1'b0;
      data_stb <= 1'b0;
    end else begin
      cmd_stb  <= 1'b0;
      data_stb <= 1'b0;
      if (sck_rise) begin
        rx_sr   <= {rx_sr[5:0], di_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {rx_sr, di_s};
          if (have_cmd) begin
            data_stb <= 1'b1;
          end else begin
            cmd      <= {rx_sr, di_s};
            have_cmd <= 1'b1;
            cmd_stb  <= 1'b1;
          end
        end
      end
      if (sck_fall) begin
        if (bit_cnt == 3'd0) tx_sr <= tx_next;
        else                 tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign spi_do = tx_sr[7];

  // FIFO handshake: push_valid offers an entry, accepted when not full or when a
  // pop frees a slot the same cycle; pop fires when non-empty, ioctl_wait is low
  // and no strobe is in flight.
  logic            push_valid, push_ok, pop, dl_done;
  logic [15:0]     push_w16;
  logic [EW-1:0]   push_entry;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [FW-1:0]   wr_ptr, rd_ptr;
  logic [FW:0]     count;

  logic [CW-1:0]   cnf_ptr;
  logic            cnf_stop;
  logic [SW-1:0]   stat_ptr;
  logic [AW-1:0]   dl_addr;
  logic [7:0]      dl_lo;
  logic            dl_half, ending;

  always_comb begin
    push_valid = 1'b0;
    push_w16   = 16'h0000;
    if (data_stb && cmd == 8'h61 && ioctl_download) begin
      if (DW == 16) begin
        if (dl_half) begin
          push_valid = 1'b1;
          push_w16   = {rx_byte, dl_lo};
        end
      end else begin
        push_valid = 1'b1;
        push_w16   = {8'h00, rx_byte};
      end
    end else if (cmd_stb && cmd == 8'h62 && ioctl_download && dl_half) begin
      push_valid = 1'b1;
      push_w16   = {8'h00, dl_lo};
    end
  end

  assign push_entry = {dl_addr, push_w16[DW-1:0]};
  assign pop        = (count != '0) && !ioctl_wait && !ioctl_wr;
  assign push_ok    = push_valid && ((count != FULL) || pop);
  assign dl_done    = ending && (count == '0) && !ioctl_wr && !push_valid && !cmd_stb;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      status         <= '0;
      core_mod       <= 7'h00;
      config_buffer  <= '0;
      cnf_ptr        <= CW'(CFG_BYTES - 1);
      cnf_stop       <= 1'b0;
      stat_ptr       <= '0;
      conf_addr      <= 10'd0;
      ioctl_index    <= 8'h00;
      ioctl_download <= 1'b0;
      ioctl_err      <= 1'b0;
      dl_addr        <= '0;
      dl_lo          <= 8'h00;
      dl_half        <= 1'b0;
      ending         <= 1'b0;
    end else begin
      if (ss_hi) begin
        cnf_ptr   <= CW'(CFG_BYTES - 1);
        cnf_stop  <= 1'b0;
        stat_ptr  <= '0;
        conf_addr <= 10'd0;
      end else if (data_stb) begin
        case (cmd)
          8'h14: conf_addr <= conf_addr + 10'd1;
          8'h15: begin
            for (int i = 0; i < STATUS_BYTES; i++)
              if (stat_ptr == SW'(i)) status[8*(STATUS_BYTES-1-i) +: 8] <= rx_byte;
            if (stat_ptr == SW'(STATUS_BYTES)) core_mod <= rx_byte[6:0];
            if (stat_ptr <= SW'(STATUS_BYTES)) stat_ptr <= stat_ptr + SW'(1);
          end
          8'h60: if (!cnf_stop) begin
            for (int i = 0; i < CFG_BYTES; i++)
              if (cnf_ptr == CW'(i)) config_buffer[8*i +: 8] <= rx_byte;
            if (cnf_ptr == '0) cnf_stop <= 1'b1;
            else               cnf_ptr  <= cnf_ptr - CW'(1);
          end
          8'h55: ioctl_index <= rx_byte;
          8'h61: if (DW == 16 && ioctl_download) begin
            dl_lo   <= rx_byte;
            dl_half <= ~dl_half;
          end
          default: ;
        endcase
      end else if (cmd_stb) begin
        if (cmd == 8'h61) begin
          ending <= 1'b0;
          if (!ioctl_download) begin
            ioctl_download <= 1'b1;
            ioctl_err      <= 1'b0;
            dl_addr        <= '0;
            dl_half        <= 1'b0;
          end
        end else if (cmd == 8'h62 && ioctl_download) begin
          ending  <= 1'b1;
          dl_half <= 1'b0;
        end
      end
      if (push_valid) dl_addr <= dl_addr + STEP;
      if (push_valid && !push_ok) ioctl_err <= 1'b1;
      if (dl_done) begin
        ioctl_download <= 1'b0;
        ending         <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wr   <= 1'b0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
    end else begin
      ioctl_wr <= pop;
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + FW'(1);
      end
      if (pop) begin
        ioctl_addr <= mem[rd_ptr][EW-1:DW];
        ioctl_dout <= mem[rd_ptr][DW-1:0];
        rd_ptr     <= rd_ptr + FW'(1);
      end
      if (push_ok && !pop)      count <= count + (FW+1)'(1);
      else if (!push_ok && pop) count <= count - (FW+1)'(1);
    end
  end

endmodule

// File: tb/tb_data_io_sync.sv
// Directed bench for data_io_sync: an 8-bit and a 16-bit download instance share
// the SPI bus; write strobes are captured and matched against expected queues.
module tb_data_io_sync;

  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck = 1'b0, spi_ss2 = 1'b1, spi_di = 1'b0;
  logic [7:0] data_in = 8'hC3;
  logic ioctl_wait = 1'b0;

  logic        do8, oe8, dl8, wr8, err8;
  logic [9:0]  ca8;
  logic [7:0]  chr8, idx8;
  logic [31:0] st8;
  logic [6:0]  cm8;
  logic [127:0] cfg8;
  logic [24:0] addr8;
  logic [7:0]  dout8;

  logic        do16, oe16, dl16, wr16, err16;
  logic [9:0]  ca16;
  logic [7:0]  chr16, idx16;
  logic [31:0] st16;
  logic [6:0]  cm16;
  logic [127:0] cfg16;
  logic [24:0] addr16;
  logic [15:0] dout16;

  assign chr8  = ca8[7:0] ^ 8'h5A;
  assign chr16 = ca16[7:0] ^ 8'h5A;

  always #5 clk_sys = ~clk_sys;

  data_io_sync #(.DW(8)) u_dut8 (
    .clk_sys(clk_sys), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss2(spi_ss2),
    .spi_di(spi_di), .spi_do(do8), .spi_do_oe(oe8), .data_in(data_in),
    .conf_addr(ca8), .conf_chr(chr8), .status(st8), .core_mod(cm8),
    .config_buffer(cfg8), .ioctl_download(dl8), .ioctl_index(idx8),
    .ioctl_wr(wr8), .ioctl_addr(addr8), .ioctl_dout(dout8),
    .ioctl_wait(ioctl_wait), .ioctl_err(err8));

  data_io_sync #(.DW(16)) u_dut16 (
    .clk_sys(clk_sys), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss2(spi_ss2),
    .spi_di(spi_di), .spi_do(do16), .spi_do_oe(oe16), .data_in(data_in),
    .conf_addr(ca16), .conf_chr(chr16), .status(st16), .core_mod(cm16),
    .config_buffer(cfg16), .ioctl_download(dl16), .ioctl_index(idx16),
    .ioctl_wr(wr16), .ioctl_addr(addr16), .ioctl_dout(dout16),
    .ioctl_wait(ioctl_wait), .ioctl_err(err16));

  int n_assert = 0;
  int n_fail = 0;
  logic [47:0] exp8_q[$], exp16_q[$], act8_q[$], act16_q[$];

  always @(negedge clk_sys) begin
    if (wr8)  act8_q.push_back({7'b0, addr8, 8'h00, dout8});
    if (wr16) act16_q.push_back({7'b0, addr16, dout16});
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_begin();
    spi_ss2 = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #80 spi_ss2 = 1'b1;
    #100;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_di = tx[i];
      #40;
      rx[i] = do8;
      spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (!dl8 && !dl16) break;
      @(posedge clk_sys);
    end
    #2;
    check(tag, {dl8, dl16}, 2'b00);
  endtask

  task automatic compare_wr(input string tag);
    check({tag, "_n8"}, act8_q.size(), exp8_q.size());
    check({tag, "_n16"}, act16_q.size(), exp16_q.size());
    while (act8_q.size() > 0 && exp8_q.size() > 0)
      check({tag, "_wr8"}, act8_q.pop_front(), exp8_q.pop_front());
    while (act16_q.size() > 0 && exp16_q.size() > 0)
      check({tag, "_wr16"}, act16_q.pop_front(), exp16_q.pop_front());
    act8_q.delete(); act16_q.delete(); exp8_q.delete(); exp16_q.delete();
  endtask

  function automatic logic [47:0] e8(input logic [24:0] a, input logic [7:0] d);
    return {7'b0, a, 8'h00, d};
  endfunction

  function automatic logic [47:0] e16(input logic [24:0] a, input logic [15:0] d);
    return {7'b0, a, d};
  endfunction

  initial begin
    logic [7:0] r;
    // reset state
    #22;
    check("rst_outs8", {do8, oe8, dl8, wr8, err8, ca8, idx8, cm8, addr8, dout8}, '0);
    check("rst_stat_cfg8", {st8, cfg8[95:0]}, '0);
    check("rst_outs16", {do16, oe16, dl16, wr16, err16, dout16}, '0);
    rst_n = 1'b1;
    #100;
    check("idle_outs", {oe8, dl8, wr8, err8, st8, cm8}, '0);

    // ACK on command and data bytes
    spi_begin();
    check("oe_active", oe8, 1'b1);
    spi_byte(8'h00, r); check("ack_cmd", r, 8'h4B);
    spi_byte(8'h99, r); check("ack_data", r, 8'h4B);
    spi_end();
    check("oe_idle", {oe8, oe16}, 2'b00);

    // status and core_mod, extra byte ignored
    spi_begin();
    spi_byte(8'h15, r); spi_byte(8'h12, r); spi_byte(8'h34, r); spi_byte(8'h56, r);
    spi_byte(8'h78, r); spi_byte(8'h05, r); spi_byte(8'hFF, r);
    spi_end();
    check("status", st8, 32'h12345678);
    check("core_mod", cm8, 7'h05);

    // config bytes fill from the top
    spi_begin();
    spi_byte(8'h60, r); spi_byte(8'hA0, r); spi_byte(8'hA1, r);
    spi_end();
    check("config", cfg8, {8'hA0, 8'hA1, 112'h0});

    // file index, last byte wins
    spi_begin();
    spi_byte(8'h55, r); spi_byte(8'h03, r); spi_byte(8'h07, r);
    spi_end();
    check("index", idx8, 8'h07);

    // config string readback
    spi_begin();
    spi_byte(8'h14, r); check("cmd14_ack", r, 8'h4B);
    spi_byte(8'h00, r); check("conf_chr0", r, 8'h5A);
    spi_byte(8'h00, r); check("conf_chr1", r, 8'h5B);
    spi_byte(8'h00, r); check("conf_chr2", r, 8'h58);
    #40 check("conf_addr", ca8, 10'd3);
    spi_end();
    check("conf_addr_clr", ca8, 10'd0);

    // data_in and unknown command
    spi_begin(); spi_byte(8'h10, r); spi_byte(8'h00, r); spi_end();
    check("data_in", r, 8'hC3);
    spi_begin(); spi_byte(8'h33, r); spi_byte(8'h00, r); spi_end();
    check("unknown_miso", r, 8'h00);
    check("unknown_noeff", {st8, cm8, idx8}, {32'h12345678, 7'h05, 8'h07});

    // download with odd byte count, then end
    spi_begin();
    spi_byte(8'h61, r); spi_byte(8'h11, r); spi_byte(8'h22, r); spi_byte(8'h33, r);
    spi_end();
    check("dl_active", {dl8, dl16}, 2'b11);
    spi_begin(); spi_byte(8'h62, r); spi_end();
    wait_idle("dl1_end");
    exp8_q.push_back(e8(0, 8'h11)); exp8_q.push_back(e8(1, 8'h22)); exp8_q.push_back(e8(2, 8'h33));
    exp16_q.push_back(e16(0, 16'h2211)); exp16_q.push_back(e16(2, 16'h0033));
    compare_wr("dl1");
    check("dl1_err", {err8, err16}, 2'b00);

    // overflow while the loader is busy
    ioctl_wait = 1'b1;
    spi_begin();
    spi_byte(8'h61, r);
    spi_byte(8'h01, r); spi_byte(8'h02, r); spi_byte(8'h03, r);
    spi_byte(8'h04, r); spi_byte(8'h05, r); spi_byte(8'h06, r);
    spi_end();
    #200;
    check("ovf_nowr", act8_q.size() + act16_q.size(), 0);
    check("ovf_err", {err8, err16}, 2'b10);
    ioctl_wait = 1'b0;
    #300;
    spi_begin(); spi_byte(8'h62, r); spi_end();
    wait_idle("ovf_end");
    for (int i = 0; i < 4; i++) exp8_q.push_back(e8(i, 8'(i + 1)));
    exp16_q.push_back(e16(0, 16'h0201)); exp16_q.push_back(e16(2, 16'h0403));
    exp16_q.push_back(e16(4, 16'h0605));
    compare_wr("ovf");
    check("err_sticky", err8, 1'b1);

    // chunked download across two transactions
    spi_begin(); spi_byte(8'h61, r); spi_byte(8'hAA, r); spi_byte(8'hBB, r); spi_end();
    check("err_clr", err8, 1'b0);
    spi_begin(); spi_byte(8'h61, r); spi_byte(8'hCC, r); spi_byte(8'hDD, r); spi_end();
    spi_begin(); spi_byte(8'h62, r); spi_end();
    wait_idle("chunk_end");
    exp8_q.push_back(e8(0, 8'hAA)); exp8_q.push_back(e8(1, 8'hBB));
    exp8_q.push_back(e8(2, 8'hCC)); exp8_q.push_back(e8(3, 8'hDD));
    exp16_q.push_back(e16(0, 16'hBBAA)); exp16_q.push_back(e16(2, 16'hDDCC));
    compare_wr("chunk");

    // reset mid-stream drops everything
    ioctl_wait = 1'b1;
    spi_begin(); spi_byte(8'h61, r); spi_byte(8'h01, r); spi_byte(8'h02, r); spi_end();
    check("mid_dl", {dl8, dl16}, 2'b11);
    rst_n = 1'b0;
    #20;
    check("mid_rst", {dl8, dl16, st8, idx8}, '0);
    rst_n = 1'b1;
    ioctl_wait = 1'b0;
    #300;
    check("mid_nowr", act8_q.size() + act16_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
